// File: rtl/aes_pkg.sv
// Shared types, constants and byte-index helpers for the AES round datapath.
package aes_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } sbsr_state_t;

   localparam int unsigned AES_STATE_BYTES = 16;

   // Byte i sits at row i%4, column i/4; ShiftRows moves it to column (c - r) mod 4.
   function automatic logic [3:0] shift_rows_idx(input logic [3:0] i);
      logic [1:0] r;
      logic [1:0] c;
      r = i[1:0];
      c = i[3:2];
      return {c - r, r};
   endfunction

   function automatic logic [7:0] state_byte(input logic [127:0] state, input logic [3:0] i);
      return state[8 * (AES_STATE_BYTES - 1 - int'(i)) +: 8];
   endfunction

endpackage

// File: rtl/sub_bytes.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module sub_bytes (
   input  logic [7:0] data_i,
   output logic [7:0] data_o
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] a, input int unsigned n);
      return (a << n) | (a >> (8 - n));
   endfunction

   logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

   // x^254 is the inverse for nonzero x and maps 0 to 0, as the S-box requires.
   always_comb begin
      x2   = gf_mul(data_i, data_i);
      x3   = gf_mul(x2, data_i);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      x252 = gf_mul(x240, x12);
      inv  = gf_mul(x252, x2);
      data_o = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
   end

endmodule

// File: rtl/sub_shift_serial.sv
// Byte-serial SubBytes + ShiftRows: LANES S-boxes per cycle, results land directly in their
// ShiftRows slot of the output register.
module sub_shift_serial
   import aes_pkg::*;
#(
   parameter int unsigned LANES = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
      $error("sub_shift_serial: LANES must be 1, 2 or 4");
   end

   localparam logic [3:0] LastCnt = 4'(AES_STATE_BYTES / LANES - 1);

   sbsr_state_t  state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [127:0] src_q, src_d;
   logic [127:0] res_q, res_d;

   logic [3:0] src_idx [LANES];
   logic [3:0] dst_idx [LANES];
   logic [7:0] sb_in   [LANES];
   logic [7:0] sb_out  [LANES];

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign src_idx[k] = cnt_q * 4'(LANES) + 4'(k);
      assign dst_idx[k] = shift_rows_idx(src_idx[k]);
      assign sb_in[k]   = state_byte(src_q, src_idx[k]);

      sub_bytes u_sbox (
         .data_i (sb_in[k]),
         .data_o (sb_out[k])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      src_d   = src_q;
      res_d   = res_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               src_d   = in_state;
               cnt_d   = 4'd0;
               state_d = StRun;
            end
         end
         StRun: begin
            for (int k = 0; k < int'(LANES); k++) begin
               res_d[8 * (AES_STATE_BYTES - 1 - int'(dst_idx[k])) +: 8] = sb_out[k];
            end
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LastCnt) state_d = StDone;
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         src_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         src_q   <= src_d;
         res_q   <= res_d;
      end
   end

   // Handshake outputs come straight from the state register.
   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign out_state = res_q;

endmodule

// File: tb/tb_sub_shift_serial.sv
// Directed bench for sub_shift_serial at LANES = 1, 2 and 4 against a table-driven model.
module tb_sub_shift_serial;

   localparam logic [127:0] FipsIn  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] FipsOut = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] AllSix3 = 128'h63636363636363636363636363636363;

   logic [2047:0] sbox_tbl = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid_a, in_valid_b, out_ready;
   logic [127:0] in_state;
   logic         in_ready  [3];
   logic         out_valid [3];
   logic         busy      [3];
   logic [127:0] out_state [3];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   sub_shift_serial #(.LANES(1)) u_l1 (
      .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready[0]),
      .in_state(in_state), .out_valid(out_valid[0]), .out_ready(out_ready),
      .out_state(out_state[0]), .busy(busy[0])
   );
   sub_shift_serial #(.LANES(2)) u_l2 (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready[1]),
      .in_state(in_state), .out_valid(out_valid[1]), .out_ready(out_ready),
      .out_state(out_state[1]), .busy(busy[1])
   );
   sub_shift_serial #(.LANES(4)) u_l4 (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready[2]),
      .in_state(in_state), .out_valid(out_valid[2]), .out_ready(out_ready),
      .out_state(out_state[2]), .busy(busy[2])
   );

   function automatic logic [127:0] ref_sbsr(input logic [127:0] x);
      logic [127:0] y;
      logic [7:0]   b;
      int           r, c, dst;
      y = '0;
      for (int i = 0; i < 16; i++) begin
         r   = i % 4;
         c   = i / 4;
         dst = 4 * ((c - r + 4) % 4) + r;
         b   = x[127 - 8 * i -: 8];
         y[127 - 8 * dst -: 8] = sbox_tbl[2047 - 8 * int'(b) -: 8];
      end
      return y;
   endfunction

   // Presents x for exactly one accepting edge; returns 1 ns after that edge.
   task automatic accept(input logic [127:0] x, input bit all3);
      @(negedge clk);
      in_state   = x;
      in_valid_a = 1'b1;
      in_valid_b = all3;
      @(posedge clk);
      #1;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
   endtask

   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      for (int j = 0; j < 3; j++) begin
         vectors += 4;
         if (in_ready[j] !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", j, in_ready[j]);
         end
         if (out_valid[j] !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", j, out_valid[j]);
         end
         if (busy[j] !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy[%0d]: got %b expected 0", j, busy[j]);
         end
         if (out_state[j] !== 128'h0) begin
            miscompares++; $display("FAIL reset_out_state[%0d]: got %h expected 0", j, out_state[j]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_fips();
      int n;
      accept(FipsIn, 1'b0);
      n = 0;
      while (n < 40 && out_valid[0] !== 1'b1) begin
         @(posedge clk); n++; @(negedge clk);
      end
      vectors += 2;
      if (n !== 16) begin
         miscompares++; $display("FAIL fips_latency: got %0d expected 16", n);
      end
      if (out_state[0] !== FipsOut) begin
         miscompares++; $display("FAIL fips_out: got %h expected %h", out_state[0], FipsOut);
      end
      release_out();
      @(negedge clk);
      vectors++;
      if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL fips_idle_after: got in_ready=%b busy=%b expected 1/0", in_ready[0], busy[0]);
      end
   endtask

   task automatic test_all_zero();
      int lat [3];
      int exp_lat [3];
      exp_lat = '{16, 8, 4};
      lat = '{-1, -1, -1};
      accept(128'h0, 1'b1);
      for (int cyc = 1; cyc <= 24; cyc++) begin
         @(posedge clk); @(negedge clk);
         for (int j = 0; j < 3; j++) if (lat[j] < 0 && out_valid[j] === 1'b1) lat[j] = cyc;
      end
      for (int j = 0; j < 3; j++) begin
         vectors += 2;
         if (lat[j] !== exp_lat[j]) begin
            miscompares++; $display("FAIL zero_latency[%0d]: got %0d expected %0d", j, lat[j], exp_lat[j]);
         end
         if (out_state[j] !== AllSix3) begin
            miscompares++; $display("FAIL zero_out[%0d]: got %h expected %h", j, out_state[j], AllSix3);
         end
      end
      release_out();
   endtask

   task automatic test_backpressure();
      logic [127:0] x, exp;
      int n;
      x   = 128'h00112233445566778899aabbccddeeff;
      exp = ref_sbsr(x);
      accept(x, 1'b0);
      n = 0;
      while (n < 40 && out_valid[0] !== 1'b1) begin
         @(posedge clk); n++; @(negedge clk);
      end
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(posedge clk); @(negedge clk);
         vectors++;
         if (out_valid[0] !== 1'b1 || out_state[0] !== exp || in_ready[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold cyc %0d: got valid=%b ready=%b out=%h expected 1/0/%h",
                     cyc, out_valid[0], in_ready[0], out_state[0], exp);
         end
      end
      release_out();
      @(negedge clk);
      vectors++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_state[0] !== exp) begin
         miscompares++;
         $display("FAIL stall_release: got ready=%b valid=%b out=%h expected 1/0/%h",
                  in_ready[0], out_valid[0], out_state[0], exp);
      end
   endtask

   task automatic test_busy_input();
      int n;
      accept(FipsIn, 1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (in_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL busy_flags: got ready=%b busy=%b expected 0/1", in_ready[0], busy[0]);
      end
      in_state   = {128{1'b1}};
      in_valid_a = 1'b1;
      @(posedge clk);
      #1;
      in_valid_a = 1'b0;
      n = 0;
      while (n < 40 && out_valid[0] !== 1'b1) begin
         @(posedge clk); n++; @(negedge clk);
      end
      vectors++;
      if (out_state[0] !== FipsOut) begin
         miscompares++; $display("FAIL busy_ignore: got %h expected %h", out_state[0], FipsOut);
      end
      release_out();
   endtask

   task automatic test_reset_mid_run();
      int n;
      accept(FipsIn, 1'b0);
      repeat (6) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1 ||
          out_state[0] !== 128'h0) begin
         miscompares++;
         $display("FAIL midrun_reset: got valid=%b busy=%b ready=%b out=%h expected 0/0/1/0",
                  out_valid[0], busy[0], in_ready[0], out_state[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      accept(FipsIn, 1'b0);
      n = 0;
      while (n < 40 && out_valid[0] !== 1'b1) begin
         @(posedge clk); n++; @(negedge clk);
      end
      vectors += 2;
      if (n !== 16) begin
         miscompares++; $display("FAIL midrun_relatency: got %0d expected 16", n);
      end
      if (out_state[0] !== FipsOut) begin
         miscompares++; $display("FAIL midrun_rerun: got %h expected %h", out_state[0], FipsOut);
      end
      release_out();
   endtask

   task automatic test_back_to_back();
      logic [127:0] q [$];
      logic [127:0] x;
      int sent, got, cyc, last;
      sent = 0; got = 0; cyc = 0; last = -1;
      out_ready = 1'b1;
      while (got < 100 && cyc < 2500) begin
         @(negedge clk);
         cyc++;
         if (out_valid[0] === 1'b1) begin
            vectors++;
            if (q.size() == 0) begin
               miscompares++; $display("FAIL b2b_spurious: got output %h expected none", out_state[0]);
            end else begin
               if (out_state[0] !== q[0]) begin
                  miscompares++;
                  $display("FAIL b2b_out #%0d: got %h expected %h", got, out_state[0], q[0]);
               end
               void'(q.pop_front());
            end
            if (last >= 0) begin
               vectors++;
               if (cyc - last !== 18) begin
                  miscompares++; $display("FAIL b2b_period #%0d: got %0d expected 18", got, cyc - last);
               end
            end
            last = cyc;
            got++;
         end
         if (in_ready[0] === 1'b1 && sent < 100) begin
            x = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_state = x;
            q.push_back(ref_sbsr(x));
            in_valid_a = 1'b1;
            sent++;
         end else begin
            in_valid_a = 1'b0;
         end
      end
      in_valid_a = 1'b0;
      out_ready  = 1'b0;
      vectors++;
      if (got !== 100) begin
         miscompares++; $display("FAIL b2b_count: got %0d expected 100", got);
      end
   endtask

   initial begin
      rst        = 1'b1;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      out_ready  = 1'b0;
      in_state   = '0;
      test_reset();
      test_fips();
      test_all_zero();
      test_backpressure();
      test_busy_input();
      test_reset_mid_run();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
